nrisc_ula: RTL and testbench

Combinational 16-bit arithmetic/logic unit (ULA) of the NRISC processor datapath. It takes two operands from the register file, applies one of ten operations selected by a 4-bit control code, and produces a 16-bit result plus a 3-bit flag vector. Both outputs reach the datapath's result and flag capture logic in the same cycle. The clock and reset ports exist for datapath interface uniformity; the block holds no state.

---
 rtl/nrisc_ula.sv | 108 ++++++++++
 tb/tb_nrisc_ula.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/nrisc_ula.sv
// nrisc_ula: combinational 16-bit ALU of the NRISC datapath, ten operations, {N, reserved, C} flags.
// Optional rotate support (RTR/RTL) is enabled by defining NRISC_ULA_ROTATE_EN.
module nrisc_ula #(
  parameter int TAM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TAM-1:0] ULA_A,
  input  logic [TAM-1:0] ULA_B,
  input  logic [3:0]     ULA_ctrl,
  input  logic           incdec,
  input  logic           cmp2,
  output logic [TAM-1:0] ULA_OUT,
  output logic [2:0]     ULA_flags
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_RTR = 4'b1101;
  localparam logic [3:0] OP_RTL = 4'b1110;

  // Flag bit 1 is reserved and tied low.
  function automatic logic [2:0] pack_flags(input logic n, input logic c);
    return {n, 1'b0, c};
  endfunction

  logic [TAM-1:0] b_eff;
  logic [TAM:0]   sum_ext;
  logic [TAM:0]   diff_ext;
  logic [TAM:0]   sum_raw;

  // clk and rst are interface-only ports; the block holds no state.
  logic unused_ports;
  assign unused_ports = clk ^ rst;

  // Sign-extended adders; sum_raw ignores incdec and feeds the AND carry flag.
  always_comb begin
    b_eff    = incdec ? {{(TAM-1){1'b0}}, 1'b1} : ULA_B;
    sum_ext  = {ULA_A[TAM-1], ULA_A} + {b_eff[TAM-1], b_eff};
    diff_ext = {ULA_A[TAM-1], ULA_A} - {b_eff[TAM-1], b_eff};
    sum_raw  = {ULA_A[TAM-1], ULA_A} + {ULA_B[TAM-1], ULA_B};
  end

  // Operation select and flag generation.
  always_comb begin
    ULA_OUT   = {TAM{1'b0}};
    ULA_flags = 3'b000;
    case (ULA_ctrl)
      OP_ADD: begin
        ULA_OUT   = sum_ext[TAM-1:0];
        ULA_flags = pack_flags(sum_ext[TAM-1], sum_ext[TAM]);
      end
      OP_SUB: begin
        if (cmp2) begin
          ULA_OUT = ULA_A;
        end else begin
          ULA_OUT = diff_ext[TAM-1:0];
        end
        ULA_flags = pack_flags(diff_ext[TAM-1], diff_ext[TAM]);
      end
      OP_AND: begin
        ULA_OUT   = ULA_A & ULA_B;
        ULA_flags = pack_flags(1'b0, sum_raw[TAM]);
      end
      OP_OR: begin
        ULA_OUT   = ULA_A | ULA_B;
        ULA_flags = 3'b000;
      end
      OP_XOR: begin
        ULA_OUT   = ULA_A ^ ULA_B;
        ULA_flags = 3'b000;
      end
      OP_SHR: begin
        ULA_OUT   = {1'b0, ULA_A[TAM-1:1]};
        ULA_flags = pack_flags(1'b0, ULA_A[0]);
      end
      OP_SHL: begin
        ULA_OUT   = {ULA_A[TAM-2:0], 1'b0};
        ULA_flags = pack_flags(1'b0, ULA_A[TAM-1]);
      end
      OP_NOT: begin
        ULA_OUT   = ~ULA_A;
        ULA_flags = 3'b000;
      end
`ifdef NRISC_ULA_ROTATE_EN
      OP_RTR: begin
        ULA_OUT   = {ULA_A[0], ULA_A[TAM-1:1]};
        ULA_flags = 3'b000;
      end
      OP_RTL: begin
        ULA_OUT   = {ULA_A[TAM-2:0], ULA_A[TAM-1]};
        ULA_flags = 3'b000;
      end
`endif
      default: begin
        ULA_OUT   = {TAM{1'b0}};
        ULA_flags = 3'b000;
      end
    endcase
  end

endmodule

// File: tb/tb_nrisc_ula.sv
// Testbench for nrisc_ula: randomized stimulus checked every cycle against an arithmetic model,
// plus hand-computed vectors that pin both the model and the DUT.
module tb_nrisc_ula;

  logic        clk;
  logic        rst;
  logic [15:0] ULA_A;
  logic [15:0] ULA_B;
  logic [3:0]  ULA_ctrl;
  logic        incdec;
  logic        cmp2;
  logic [15:0] ULA_OUT;
  logic [2:0]  ULA_flags;

  int checks   = 0;
  int failures = 0;
  logic cmp_en = 1'b0;

  nrisc_ula dut (
    .clk      (clk),
    .rst      (rst),
    .ULA_A    (ULA_A),
    .ULA_B    (ULA_B),
    .ULA_ctrl (ULA_ctrl),
    .incdec   (incdec),
    .cmp2     (cmp2),
    .ULA_OUT  (ULA_OUT),
    .ULA_flags(ULA_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic on signed values, result {out[15:0], flags[2:0]}.
  function automatic logic [18:0] model(input logic [3:0] c, input logic [15:0] a,
                                        input logic [15:0] b, input logic inc, input logic cmp);
    logic signed [31:0] sa, sb, sbr, t;
    logic [16:0] s, d, sr;
    logic [15:0] o;
    logic [2:0]  f;
    sa  = 32'($signed(a));
    sbr = 32'($signed(b));
    sb  = inc ? 32'sd1 : sbr;
    t = sa + sb;  s  = t[16:0];
    t = sa - sb;  d  = t[16:0];
    t = sa + sbr; sr = t[16:0];
    o = 16'h0000;
    f = 3'b000;
    case (c)
      4'd0:  begin o = s[15:0]; f = {s[15], 1'b0, s[16]}; end
      4'd1:  begin o = cmp ? a : d[15:0]; f = {d[15], 1'b0, d[16]}; end
      4'd2:  begin o = a & b; f = {2'b00, sr[16]}; end
      4'd3:  o = a | b;
      4'd4:  o = a ^ b;
      4'd5:  begin o = a >> 1; f = {2'b00, a[0]}; end
      4'd6:  begin o = a << 1; f = {2'b00, a[15]}; end
      4'd7:  o = ~a;
`ifdef NRISC_ULA_ROTATE_EN
      4'd13: o = (a >> 1) | (a << 15);
      4'd14: o = (a << 1) | (a >> 15);
`endif
      default: begin o = 16'h0000; f = 3'b000; end
    endcase
    return {o, f};
  endfunction

  // Every cycle: DUT outputs must equal the model for the inputs currently applied.
  always @(negedge clk) begin
    logic [18:0] exp_v;
    if (cmp_en) begin
      exp_v = model(ULA_ctrl, ULA_A, ULA_B, incdec, cmp2);
      checks++;
      if ({ULA_OUT, ULA_flags} !== exp_v) begin
        failures++;
        $display("FAIL model_cmp ctrl=%b A=%h B=%h inc=%b cmp2=%b rst=%b: got out=%h flags=%b, want out=%h flags=%b",
                 ULA_ctrl, ULA_A, ULA_B, incdec, cmp2, rst, ULA_OUT, ULA_flags, exp_v[18:3], exp_v[2:0]);
      end
    end
  end

  task automatic drive(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                       input logic inc, input logic cmp);
    @(posedge clk);
    #1;
    ULA_ctrl = c; ULA_A = a; ULA_B = b; incdec = inc; cmp2 = cmp;
  endtask

  // Hand-computed vector: pins the model and checks the DUT directly.
  task automatic directed(input string name, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic inc, input logic cmp,
                          input logic [15:0] eo, input logic [2:0] ef);
    logic [18:0] mv;
    drive(c, a, b, inc, cmp);
    mv = model(c, a, b, inc, cmp);
    checks++;
    if (mv !== {eo, ef}) begin
      failures++;
      $display("FAIL %s model: got %h/%b, want %h/%b", name, mv[18:3], mv[2:0], eo, ef);
    end
    @(negedge clk);
    checks++;
    if ({ULA_OUT, ULA_flags} !== {eo, ef}) begin
      failures++;
      $display("FAIL %s dut: got %h/%b, want %h/%b", name, ULA_OUT, ULA_flags, eo, ef);
    end
  endtask

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; ULA_A = 16'h0000; ULA_B = 16'h0000; ULA_ctrl = 4'b0000; incdec = 1'b0; cmp2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ULA_OUT, ULA_flags} !== 19'h0) begin
      failures++;
      $display("FAIL reset_state: got %h/%b, want 0000/000", ULA_OUT, ULA_flags);
    end
    cmp_en = 1'b1;
    rst = 1'b0;

    directed("add_ovf",  4'b0000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 3'b100);
    directed("add_neg",  4'b0000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 3'b101);
    directed("inc",      4'b0000, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 3'b000);
    directed("sub",      4'b0001, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'hFFFE, 3'b101);
    directed("cmp",      4'b0001, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0003, 3'b101);
    directed("dec",      4'b0001, 16'h0000, 16'h1234, 1'b1, 1'b0, 16'hFFFF, 3'b101);
    directed("and",      4'b0010, 16'h8001, 16'h8003, 1'b0, 1'b0, 16'h8001, 3'b001);
    directed("and_inc",  4'b0010, 16'h8001, 16'h8003, 1'b1, 1'b0, 16'h8001, 3'b001);
    directed("or",       4'b0011, 16'h8001, 16'h8003, 1'b0, 1'b0, 16'h8003, 3'b000);
    directed("xor",      4'b0100, 16'h8001, 16'h8003, 1'b0, 1'b0, 16'h0002, 3'b000);
    directed("shr",      4'b0101, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h4000, 3'b001);
    directed("shl",      4'b0110, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0002, 3'b001);
`ifdef NRISC_ULA_ROTATE_EN
    directed("rtr",      4'b1101, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'hC000, 3'b000);
    directed("rtl",      4'b1110, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0003, 3'b000);
`else
    directed("rtr_off",  4'b1101, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'b000);
    directed("rtl_off",  4'b1110, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'b000);
`endif
    directed("not",      4'b0111, 16'h8001, 16'h0000, 1'b0, 1'b0, 16'h7FFE, 3'b000);
    directed("cmp2_add", 4'b0000, 16'h0003, 16'h0005, 1'b0, 1'b1, 16'h0008, 3'b000);
    rst = 1'b1;
    directed("bad_rst1", 4'b1010, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 3'b000);
    directed("add_rst1", 4'b0000, 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 3'b000);
    rst = 1'b0;
    directed("bad_1111", 4'b1111, 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h0000, 3'b000);

    for (int i = 0; i < 3000; i++) begin
      drive(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rst = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    @(posedge clk);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
